// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates one line-wide backing memory between icache refills and dcache refills/write-backs
module mem_arbiter #(
  parameter int LINE_W       = 128,
  parameter int LADDR_W      = 30,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ic_read,
  input  logic [LADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0]  ic_line,
  output logic               ic_ready,
  input  logic               dc_read,
  input  logic               dc_write,
  input  logic [LADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0]  dc_wline,
  output logic [LINE_W-1:0]  dc_line,
  output logic               dc_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic [LADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]  mem_wline,
  input  logic [LINE_W-1:0]  mem_line,
  input  logic               mem_ready,
  output logic               busy,
  output logic               grant_dc
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t               state_q;
  logic                 mem_read_q, mem_write_q;
  logic [LADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]    mem_wline_q, ic_line_q, dc_line_q;
  logic                 ic_ready_q, dc_ready_q, busy_q, grant_dc_q;
  logic [3:0]           starve_q, starve_d;
  logic                 dc_req, ic_win, dc_win, ic_owns;

  assign dc_req = dc_read | dc_write;
  assign ic_win = (state_q == IDLE) && ic_read && (!dc_req || starve_q >= LIMIT);
  assign dc_win = (state_q == IDLE) && dc_req && !ic_win;
  // The icache counts as granted for its whole transaction, including the RESP bubble.
  assign ic_owns = (state_q != IDLE) && !grant_dc_q;

  always_comb begin
    starve_d = starve_q;
    if (ic_win)
      starve_d = 4'd0;
    else if (ic_read && !ic_owns && starve_q < LIMIT)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wline_q <= '0;
      ic_line_q   <= '0;
      dc_line_q   <= '0;
      ic_ready_q  <= 1'b0;
      dc_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      grant_dc_q  <= 1'b0;
      starve_q    <= 4'd0;
    end else begin
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      starve_q   <= starve_d;
      case (state_q)
        IDLE: begin
          if (ic_win) begin
            state_q     <= XFER;
            mem_addr_q  <= ic_addr;
            mem_wline_q <= dc_wline;
            mem_read_q  <= 1'b1;
            busy_q      <= 1'b1;
            grant_dc_q  <= 1'b0;
          end else if (dc_win) begin
            state_q     <= XFER;
            mem_addr_q  <= dc_addr;
            mem_wline_q <= dc_wline;
            // A combined read+write request is served as the write-back only.
            mem_write_q <= dc_write;
            mem_read_q  <= !dc_write;
            busy_q      <= 1'b1;
            grant_dc_q  <= 1'b1;
          end
        end
        XFER: begin
          if (mem_ready) begin
            state_q     <= RESP;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (grant_dc_q) begin
              dc_ready_q <= 1'b1;
              if (mem_read_q) dc_line_q <= mem_line;
            end else begin
              ic_ready_q <= 1'b1;
              if (mem_read_q) ic_line_q <= mem_line;
            end
          end
        end
        RESP: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          grant_dc_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ic_line   = ic_line_q;
  assign ic_ready  = ic_ready_q;
  assign dc_line   = dc_line_q;
  assign dc_ready  = dc_ready_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wline = mem_wline_q;
  assign busy      = busy_q;
  assign grant_dc  = grant_dc_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int LINE_W  = 128;
  localparam int LADDR_W = 30;
  localparam int LAT     = 5;

  localparam logic [LINE_W-1:0] D_IC  = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [LINE_W-1:0] D_WB  = {32{4'h5}};
  localparam logic [LINE_W-1:0] D_JNK = {32{4'hF}};
  localparam logic [LINE_W-1:0] D_S1  = 128'h0101_0101_0101_0101_0101_0101_0101_0101;
  localparam logic [LINE_W-1:0] D_S2  = 128'h0202_0202_0202_0202_0202_0202_0202_0202;
  localparam logic [LINE_W-1:0] D_S3  = 128'h0303_0303_0303_0303_0303_0303_0303_0303;
  localparam logic [LINE_W-1:0] D_B1  = 128'hB1B1_0000_0000_0000_0000_0000_0000_00B1;
  localparam logic [LINE_W-1:0] D_B2  = 128'hB2B2_0000_0000_0000_0000_0000_0000_00B2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               ic_read = 1'b0;
  logic [LADDR_W-1:0] ic_addr = '0;
  logic [LINE_W-1:0]  ic_line;
  logic               ic_ready;
  logic               dc_read = 1'b0;
  logic               dc_write = 1'b0;
  logic [LADDR_W-1:0] dc_addr = '0;
  logic [LINE_W-1:0]  dc_wline = '0;
  logic [LINE_W-1:0]  dc_line;
  logic               dc_ready;
  logic               mem_read, mem_write;
  logic [LADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0]  mem_wline;
  logic [LINE_W-1:0]  mem_line = '0;
  logic               mem_ready = 1'b0;
  logic               busy, grant_dc;

  int n_checks = 0;
  int n_fail   = 0;

  logic               snap_rd, snap_wr, snap_gdc;
  logic [LADDR_W-1:0] snap_addr;
  logic [LINE_W-1:0]  snap_wline;
  int                 snap_wait, snap_hi;

  mem_arbiter #(.LINE_W(LINE_W), .LADDR_W(LADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_line(ic_line), .ic_ready(ic_ready),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wline(dc_wline),
    .dc_line(dc_line), .dc_ready(dc_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wline(mem_wline),
    .mem_line(mem_line), .mem_ready(mem_ready), .busy(busy), .grant_dc(grant_dc)
  );

  always #5 clk = ~clk;

  // Memory model: waits for a strobe, snapshots it, holds it LAT cycles, then answers once.
  // Starts and ends on a negedge; on return the ready pulse cycle is being observed.
  task automatic serve(input logic [LINE_W-1:0] rdata);
    snap_wait = 0;
    while (!(mem_read || mem_write) && snap_wait < 40) begin
      @(negedge clk);
      snap_wait++;
    end
    snap_rd = mem_read; snap_wr = mem_write; snap_addr = mem_addr;
    snap_wline = mem_wline; snap_gdc = grant_dc;
    snap_hi = 0;
    for (int i = 0; i < LAT; i++) begin
      if ((mem_read || mem_write) && mem_read === snap_rd && mem_write === snap_wr &&
          mem_addr === snap_addr && busy === 1'b1)
        snap_hi++;
      if (i == LAT - 1) begin
        mem_ready = 1'b1;
        mem_line  = rdata;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_read, mem_write, ic_ready, dc_ready, busy, grant_dc} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {mem_read, mem_write, ic_ready, dc_ready, busy, grant_dc});
    end
    n_checks++;
    if (mem_addr !== '0 || mem_wline !== '0 || ic_line !== '0 || dc_line !== '0) begin
      n_fail++; $display("FAIL reset_data: addr=%h wline=%h ic_line=%h dc_line=%h required all 0", mem_addr, mem_wline, ic_line, dc_line);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_icache_only();
    ic_read = 1'b1; ic_addr = 30'h100;
    serve(D_IC);
    n_checks++;
    if (snap_wait !== 1 || snap_rd !== 1'b1 || snap_wr !== 1'b0 || snap_addr !== 30'h100 || snap_gdc !== 1'b0) begin
      n_fail++; $display("FAIL ic_grant: wait=%0d rd=%b wr=%b addr=%h gdc=%b required 1 1 0 100 0", snap_wait, snap_rd, snap_wr, snap_addr, snap_gdc);
    end
    n_checks++;
    if (snap_hi !== LAT) begin
      n_fail++; $display("FAIL ic_strobe_hold: held %0d cycles required %0d", snap_hi, LAT);
    end
    n_checks++;
    if (ic_ready !== 1'b1 || ic_line !== D_IC || dc_ready !== 1'b0 || mem_read !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ic_resp: ic_ready=%b ic_line=%h dc_ready=%b mem_read=%b busy=%b required 1 %h 0 0 1", ic_ready, ic_line, dc_ready, mem_read, busy, D_IC);
    end
    ic_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ic_ready !== 1'b0 || busy !== 1'b0 || ic_line !== D_IC) begin
      n_fail++; $display("FAIL ic_done: ic_ready=%b busy=%b ic_line=%h required 0 0 %h", ic_ready, busy, ic_line, D_IC);
    end
  endtask

  task automatic test_writeback();
    dc_write = 1'b1; dc_read = 1'b1; dc_addr = 30'h2A; dc_wline = D_WB;
    serve(D_JNK);
    n_checks++;
    if (snap_wr !== 1'b1 || snap_rd !== 1'b0 || snap_wline !== D_WB || snap_addr !== 30'h2A || snap_gdc !== 1'b1) begin
      n_fail++; $display("FAIL wb_grant: wr=%b rd=%b wline=%h addr=%h gdc=%b required 1 0 %h 2a 1", snap_wr, snap_rd, snap_wline, snap_addr, snap_gdc, D_WB);
    end
    n_checks++;
    if (dc_ready !== 1'b1 || ic_ready !== 1'b0 || dc_line !== '0 || ic_line !== D_IC) begin
      n_fail++; $display("FAIL wb_resp: dc_ready=%b ic_ready=%b dc_line=%h ic_line=%h required 1 0 0 %h", dc_ready, ic_ready, dc_line, ic_line, D_IC);
    end
    dc_write = 1'b0; dc_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dc_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL wb_done: dc_ready=%b busy=%b required 0 0", dc_ready, busy);
    end
  endtask

  task automatic test_starvation();
    dc_read = 1'b1; dc_addr = 30'h33; ic_read = 1'b1; ic_addr = 30'h44;
    serve(D_S1);
    n_checks++;
    if (snap_gdc !== 1'b1 || snap_addr !== 30'h33 || dc_ready !== 1'b1 || dc_line !== D_S1) begin
      n_fail++; $display("FAIL starve_first: gdc=%b addr=%h dc_ready=%b dc_line=%h required 1 33 1 %h", snap_gdc, snap_addr, dc_ready, dc_line, D_S1);
    end
    serve(D_S2);
    n_checks++;
    if (snap_gdc !== 1'b0 || snap_addr !== 30'h44 || ic_ready !== 1'b1 || ic_line !== D_S2 || dc_line !== D_S1) begin
      n_fail++; $display("FAIL starve_second: gdc=%b addr=%h ic_ready=%b ic_line=%h dc_line=%h required 0 44 1 %h %h", snap_gdc, snap_addr, ic_ready, ic_line, dc_line, D_S2, D_S1);
    end
    serve(D_S3);
    n_checks++;
    if (snap_gdc !== 1'b1 || snap_addr !== 30'h33 || dc_ready !== 1'b1 || dc_line !== D_S3 || ic_line !== D_S2) begin
      n_fail++; $display("FAIL starve_third: gdc=%b addr=%h dc_ready=%b dc_line=%h ic_line=%h required 1 33 1 %h %h", snap_gdc, snap_addr, dc_ready, dc_line, ic_line, D_S3, D_S2);
    end
    dc_read = 1'b0; ic_read = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    dc_read = 1'b1; dc_addr = 30'h10;
    serve(D_B1);
    n_checks++;
    if (snap_gdc !== 1'b1 || snap_rd !== 1'b1 || dc_ready !== 1'b1 || dc_line !== D_B1) begin
      n_fail++; $display("FAIL b2b_dc: gdc=%b rd=%b dc_ready=%b dc_line=%h required 1 1 1 %h", snap_gdc, snap_rd, dc_ready, dc_line, D_B1);
    end
    dc_read = 1'b0; ic_read = 1'b1; ic_addr = 30'h20;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || dc_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_bubble: busy=%b rd=%b wr=%b dc_ready=%b required 0 0 0 0", busy, mem_read, mem_write, dc_ready);
    end
    serve(D_B2);
    n_checks++;
    if (snap_wait !== 1 || snap_gdc !== 1'b0 || snap_addr !== 30'h20 || ic_ready !== 1'b1 || ic_line !== D_B2 || dc_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ic: wait=%0d gdc=%b addr=%h ic_ready=%b ic_line=%h dc_ready=%b required 1 0 20 1 %h 0", snap_wait, snap_gdc, snap_addr, ic_ready, ic_line, dc_ready, D_B2);
    end
    ic_read = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || mem_read !== 1'b0 || ic_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: busy=%b rd=%b ic_ready=%b required 0 0 0", busy, mem_read, ic_ready);
    end
  endtask

  task automatic test_spurious_ready();
    mem_line = D_JNK; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ic_ready, dc_ready, busy, mem_read, mem_write} !== 5'b0 || ic_line !== D_B2 || dc_line !== D_B1) begin
        n_fail++; $display("FAIL spurious_%0d: ctrl=%b ic_line=%h dc_line=%h required 00000 %h %h", i, {ic_ready, dc_ready, busy, mem_read, mem_write}, ic_line, dc_line, D_B2, D_B1);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    int t;
    t = 0;
    dc_read = 1'b1; dc_addr = 30'h77; dc_wline = D_WB;
    while (!mem_read && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t !== 1) begin
      n_fail++; $display("FAIL rst_xfer_start: strobe after %0d cycles required 1", t);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || mem_read !== 1'b1) begin
      n_fail++; $display("FAIL rst_xfer_busy: busy=%b rd=%b required 1 1", busy, mem_read);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, mem_write, ic_ready, dc_ready, busy, grant_dc} !== 6'b0 || mem_addr !== '0 ||
        mem_wline !== '0 || ic_line !== '0 || dc_line !== '0) begin
      n_fail++; $display("FAIL rst_async: ctrl=%b addr=%h wline=%h ic_line=%h dc_line=%h required all 0", {mem_read, mem_write, ic_ready, dc_ready, busy, grant_dc}, mem_addr, mem_wline, ic_line, dc_line);
    end
    dc_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_line = D_JNK; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ic_ready, dc_ready, busy, mem_read, grant_dc} !== 5'b0 || dc_line !== '0) begin
        n_fail++; $display("FAIL rst_late_ready_%0d: ctrl=%b dc_line=%h required 00000 0", i, {ic_ready, dc_ready, busy, mem_read, grant_dc}, dc_line);
      end
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_icache_only();
    test_writeback();
    test_starvation();
    test_back_to_back();
    test_spurious_ready();
    test_reset_mid_xfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single line-wide backing memory (dataMemory-style port: Read/Write/Address/Line_in/Line_out/Ready) between the instruction cache (line refills only) and the data cache (line refills and write-backs).
- Sits between both caches and the memory. It sequences exactly one line transaction at a time and returns the response to the requester that was granted.
- Data-cache requests have priority; a starvation counter guarantees the instruction cache forward progress.

Parameters:
- LINE_W, 128, cache line width in bits (equals `CACHE_LINE_SIZE).
- LADDR_W, 30, line address width (equals `WORD_SIZE-2).
- STARVE_LIMIT, 4, number of cycles the instruction cache may wait while the data cache is granted before the instruction cache is forced to win. Range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- ic_read  in  1  icache refill request; held high until ic_ready.
- ic_addr  in  LADDR_W  icache line address.
- ic_line  out  LINE_W  refill line returned to the icache.
- ic_ready  out  1  one-cycle pulse; ic_line is valid in this cycle.
- dc_read  in  1  dcache refill request; held high until dc_ready.
- dc_write  in  1  dcache write-back request; held high until dc_ready.
- dc_addr  in  LADDR_W  dcache line address.
- dc_wline  in  LINE_W  dcache write-back line.
- dc_line  out  LINE_W  refill line returned to the dcache.
- dc_ready  out  1  one-cycle completion pulse to the dcache.
- mem_read  out  1  memory read strobe; level, held until mem_ready.
- mem_write  out  1  memory write strobe; level, held until mem_ready.
- mem_addr  out  LADDR_W  memory line address.
- mem_wline  out  LINE_W  memory write data.
- mem_line  in  LINE_W  memory read data; valid when mem_ready is high.
- mem_ready  in  1  memory completion.
- busy  out  1  high in every state except IDLE.
- grant_dc  out  1  high while the current transaction belongs to the dcache.

Behaviour:
- All outputs are registered. On reset (rst=0), asynchronously:
  - state=IDLE.
  - All strobes, ready pulses, busy and grant_dc are 0.
  - mem_addr, mem_wline, ic_line and dc_line are 0.
  - The starve counter is 0.
- FSM states: IDLE, XFER, RESP.
- IDLE, grant decision:
  - If no request is high, stay in IDLE.
  - If only the icache requests, grant the icache.
  - If only the dcache requests, grant the dcache.
  - If both request, grant the icache when starve >= STARVE_LIMIT; otherwise grant the dcache.
- Granting (IDLE -> XFER at the next edge):
  - Latch the address into mem_addr, and latch dc_wline into mem_wline.
  - Set grant_dc and busy.
  - For an icache grant, drive mem_read=1.
  - For a dcache grant, drive mem_write=1 if dc_write is high; otherwise drive mem_read=1. When dc_write and dc_read are both high, this is a write-back only; the dcache issues its refill as a separate request.
- XFER:
  - Strobes are held constant and requester inputs are ignored (addresses are already latched).
  - When mem_ready=1 at an edge: go to RESP, drop the strobes, and pulse the granted ready for exactly one cycle.
  - For a read, mem_line is captured into ic_line or dc_line in that same edge.
- RESP: the next edge returns to IDLE unconditionally. No grant is made in RESP; this one-cycle bubble absorbs the requester dropping its request after ready.
- Response-line persistence: ic_line and dc_line keep their last value until the next read completion for the same requester.
- Latency:
  - The request is sampled at edge E0; strobes are visible after E0.
  - The ready pulse is visible after the edge that samples mem_ready.
  - The arbiter adds exactly 2 cycles beyond the memory's own latency.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on every edge where ic_read=1 and the icache is not granted (any state).
  - Clears to 0 on the edge that grants the icache.
- mem_ready is ignored outside XFER. No ready pulse is generated from IDLE or RESP.
- Reset mid-transaction: the FSM returns to IDLE immediately. The pending transaction is abandoned and no ready pulse is issued. The requester must re-request.
- Requests that drop before their ready pulse are illegal; behaviour is undefined, but the FSM must still exit XFER on mem_ready.

Test Plan:
- Icache only: ic_read=1, ic_addr=0x100, memory returns 0xDEAD…BEEF 5 cycles after mem_read -> mem_read high with mem_addr=0x100 for 5 cycles; ic_ready is a single pulse with ic_line=0xDEAD…BEEF; dc_ready stays 0; busy falls 2 cycles after mem_ready.
- Dcache write-back with both flags set: dc_write=1, dc_read=1, dc_addr=0x2A, dc_wline=0x55…55 -> mem_write=1, mem_read=0, mem_wline=0x55…55, grant_dc=1; dc_ready pulses once; dc_line is unchanged.
- Both requesting continuously, STARVE_LIMIT=4, memory latency 5 -> the first grant goes to the dcache; after it completes, starve >= 4, so the icache is granted next. The third grant goes to the dcache.
- Back-to-back: requester drops its request the cycle after ready while the other raises its request -> no grant in RESP; the new grant follows in IDLE; no double transaction on the stale request.
- Reset asserted (rst=0) in the 3rd cycle of an XFER -> all outputs are 0 asynchronously. After release, with no requests, the FSM stays IDLE and a late mem_ready produces no ready pulse.
- Spurious mem_ready=1 in IDLE with no requests -> no state change, no ready pulses, outputs unchanged.
